// File: rtl/ir_fetch_pkg.sv
// Shared types and default sizing for the instruction fetch sequencer.
// The optional fetch timeout is enabled by defining FETCH_TIMEOUT_EN.
package ir_fetch_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_watchdog.sv
// Wait-cycle counter for a fetch byte; flags the TIMEOUT-th consecutive stall cycle.
// Only present in builds that define FETCH_TIMEOUT_EN.
`ifdef FETCH_TIMEOUT_EN
module fetch_watchdog
  import ir_fetch_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // expired marks the cycle whose stall would bring the count to TIMEOUT
  assign expired = enable && (count == LAST);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/ir_fetch_sequencer.sv
// Fetches a 16-bit instruction as two bytes (low then high) into the instruction register.
// Define FETCH_TIMEOUT_EN to abort a stalled fetch after TIMEOUT wait cycles.
//
// state    | meaning
// IDLE     | waiting for Start; PCLoad accepted here only
// FETCH_LO | reading low byte at PC, waiting on MemReady
// FETCH_HI | reading high byte at PC, waiting on MemReady
module ir_fetch_sequencer
  import ir_fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              PCLoad,
  input  logic [ADDR_W-1:0] PCIn,
  input  logic [7:0]        MemData,
  input  logic              MemReady,
  output logic              MemRead,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [7:0]        IRData,
  output logic              IRWrite,
  output logic              IRLH,
  output logic [ADDR_W-1:0] PCOut,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  if (TIMEOUT < 1) begin : g_timeout_range
    $error("ir_fetch_sequencer: TIMEOUT must be at least 1");
  end

  fetch_state_t      state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic [7:0]        ir_data, ir_data_nx;
  logic              ir_write, ir_write_nx;
  logic              ir_lh, ir_lh_nx;
  logic              done, done_nx;

`ifdef FETCH_TIMEOUT_EN
  logic              wd_clear, wd_expired;
  logic [ADDR_W-1:0] start_pc, start_pc_nx;
  logic              error_q, error_nx;

  fetch_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .Clock   (Clock),
    .Reset   (Reset),
    .clear   (wd_clear),
    .enable  ((state != IDLE) && !MemReady),
    .expired (wd_expired)
  );
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      pc       <= '0;
      ir_data  <= '0;
      ir_write <= 1'b0;
      ir_lh    <= 1'b0;
      done     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      start_pc <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      ir_data  <= ir_data_nx;
      ir_write <= ir_write_nx;
      ir_lh    <= ir_lh_nx;
      done     <= done_nx;
`ifdef FETCH_TIMEOUT_EN
      start_pc <= start_pc_nx;
      error_q  <= error_nx;
`endif
    end
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    ir_data_nx  = ir_data;
    ir_write_nx = 1'b0;
    ir_lh_nx    = ir_lh;
    done_nx     = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    start_pc_nx = start_pc;
    error_nx    = 1'b0;
    wd_clear    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (PCLoad) begin
          pc_nx = PCIn;
        end else if (Start) begin
          state_nx = FETCH_LO;
`ifdef FETCH_TIMEOUT_EN
          start_pc_nx = pc;
          wd_clear    = 1'b1;
`endif
        end
      end
      FETCH_LO: begin
        if (MemReady) begin
          ir_data_nx  = MemData;
          ir_write_nx = 1'b1;
          ir_lh_nx    = 1'b0;
          pc_nx       = pc + 1'b1;
          state_nx    = FETCH_HI;
`ifdef FETCH_TIMEOUT_EN
          wd_clear    = 1'b1;
`endif
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wd_expired) begin
          state_nx = IDLE;
          pc_nx    = start_pc;
          error_nx = 1'b1;
        end
`endif
      end
      FETCH_HI: begin
        if (MemReady) begin
          ir_data_nx  = MemData;
          ir_write_nx = 1'b1;
          ir_lh_nx    = 1'b1;
          pc_nx       = pc + 1'b1;
          done_nx     = 1'b1;
          state_nx    = IDLE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wd_expired) begin
          // abort rewinds so a retry refetches the whole instruction
          state_nx = IDLE;
          pc_nx    = start_pc;
          error_nx = 1'b1;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  assign MemRead = (state == FETCH_LO) || (state == FETCH_HI);
  assign Busy    = (state != IDLE);
  assign PCOut   = pc;
  assign MemAddr = pc;
  assign IRData  = ir_data;
  assign IRWrite = ir_write;
  assign IRLH    = ir_lh;
  assign Done    = done;
`ifdef FETCH_TIMEOUT_EN
  assign Error   = error_q;
`else
  assign Error   = 1'b0;
`endif

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
// Scoreboard bench for ir_fetch_sequencer: driver predicts IR writes, Done and Error;
// a monitor compares them as the DUT presents them. Define FETCH_TIMEOUT_EN for the timeout case.
module tb_ir_fetch_sequencer;

  localparam int TO = 15;

  logic        Clock = 1'b0;
  logic        Reset, Start, PCLoad, MemReady;
  logic [15:0] PCIn;
  logic [7:0]  MemData;
  logic        MemRead, IRWrite, IRLH, Busy, Done, Error;
  logic [15:0] MemAddr, PCOut;
  logic [7:0]  IRData;

  ir_fetch_sequencer #(.ADDR_W(16), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .PCLoad(PCLoad), .PCIn(PCIn),
    .MemData(MemData), .MemReady(MemReady), .MemRead(MemRead), .MemAddr(MemAddr),
    .IRData(IRData), .IRWrite(IRWrite), .IRLH(IRLH), .PCOut(PCOut), .Busy(Busy),
    .Done(Done), .Error(Error)
  );

  always #5 Clock = ~Clock;

  typedef struct { bit lh; logic [7:0] data; logic [15:0] pc_after; } wr_t;
  typedef struct { int cyc; logic [15:0] pc; } evt_t;

  wr_t  wr_q[$];
  evt_t done_q[$];
  evt_t err_q[$];

  logic [7:0]  mem [0:65535];
  logic [15:0] model_pc;
  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued predictions
  initial begin
    wr_t  w;
    evt_t e;
    forever begin
      @(posedge Clock);
      cyc++;
      #1;
      if (IRWrite) begin
        if (wr_q.size() == 0) chk("irwrite_unexpected", IRWrite, 0);
        else begin
          w = wr_q.pop_front();
          chk("ir_byte", {IRLH, IRData}, {w.lh, w.data});
          chk("ir_pc", PCOut, w.pc_after);
        end
      end
      if (Done) begin
        if (done_q.size() == 0) chk("done_unexpected", Done, 0);
        else begin
          e = done_q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("done_pc", PCOut, e.pc);
        end
      end
      if (Error) begin
        if (err_q.size() == 0) chk("error_unexpected", Error, 0);
        else begin
          e = err_q.pop_front();
          chk("error_cycle", cyc, e.cyc);
          chk("error_pc", PCOut, e.pc);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clock);
      Start = 0; PCLoad = 0;
      MemReady = 1'($urandom); MemData = 8'($urandom); PCIn = 16'($urandom);
      chk("idle_busy", Busy, 0);
      chk("idle_memread", MemRead, 0);
    end
    @(negedge Clock);
    MemReady = 0;
  endtask

  task automatic pcload(input logic [15:0] v, input bit with_start);
    @(negedge Clock);
    PCLoad = 1; Start = with_start; PCIn = v; MemReady = 0;
    @(negedge Clock);
    PCLoad = 0; Start = 0;
    model_pc = v;
    chk("pcload_pc", PCOut, v);
    chk("pcload_busy", Busy, 0);
  endtask

  // One byte: stall cycles with busy-time Start/PCLoad noise, then one ready cycle
  task automatic serve(input logic [15:0] addr, input int stall);
    repeat (stall) begin
      MemReady = 0; MemData = 8'($urandom);
      Start = 1'($urandom); PCLoad = 1'($urandom); PCIn = 16'($urandom);
      chk("stall_memread", MemRead, 1);
      chk("stall_addr", MemAddr, addr);
      @(negedge Clock);
    end
    chk("ready_memread", MemRead, 1);
    chk("ready_addr", MemAddr, addr);
    MemReady = 1; MemData = mem[MemAddr];
    Start = 1'($urandom); PCLoad = 1'($urandom); PCIn = 16'($urandom);
    @(negedge Clock);
    MemReady = 0; Start = 0; PCLoad = 0; MemData = 8'($urandom);
  endtask

  // mode: 0 normal, 1 reset while in FETCH_HI, 2 timeout in FETCH_HI
  task automatic do_fetch(input int stall_lo, input int stall_hi, input int mode);
    logic [15:0] a0, a1, a2;
    int t0;
    wr_t w;
    evt_t e;
    a0 = model_pc; a1 = a0 + 16'd1; a2 = a0 + 16'd2;
    @(negedge Clock);
    Start = 1; PCLoad = 0; MemReady = 0;
    t0 = cyc;
    w = '{1'b0, mem[a0], a1}; wr_q.push_back(w);
    if (mode == 0) begin
      w = '{1'b1, mem[a1], a2}; wr_q.push_back(w);
      e = '{t0 + 3 + stall_lo + stall_hi, a2}; done_q.push_back(e);
      model_pc = a2;
    end else if (mode == 1) begin
      model_pc = 16'd0;
    end else begin
      e = '{t0 + 2 + TO, a0}; err_q.push_back(e);
      model_pc = a0;
    end
    @(negedge Clock);
    Start = 0;
    chk("fetch_busy", Busy, 1);
    serve(a0, stall_lo);
    if (mode == 0) begin
      serve(a1, stall_hi);
      chk("after_busy", Busy, 0);
    end else if (mode == 1) begin
      Reset = 1; MemReady = 1; MemData = mem[a1];
      @(negedge Clock);
      Reset = 0; MemReady = 0;
      chk("rst_busy", Busy, 0);
      chk("rst_pc", PCOut, 0);
      chk("rst_irwrite", IRWrite, 0);
      chk("rst_done", Done, 0);
    end else begin
      MemReady = 0;
      repeat (TO + 1) @(negedge Clock);
      chk("to_busy", Busy, 0);
      chk("to_pc", PCOut, a0);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0040] = 8'h34; mem[16'h0041] = 8'h12;
    Reset = 1; Start = 0; PCLoad = 0; PCIn = 0; MemData = 0; MemReady = 0;
    model_pc = 0;
    repeat (3) @(negedge Clock);
    Reset = 0;
    @(negedge Clock);
    chk("reset_pc", PCOut, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_memread", MemRead, 0);
    chk("reset_ir", {IRWrite, IRLH, IRData}, 0);
    chk("reset_done_err", {Done, Error}, 0);

    pcload(16'h0040, 0);
    do_fetch(0, 0, 0);
    chk("basic_pc", PCOut, 16'h0042);
    idle(2);
    pcload(16'hFFFF, 0);
    do_fetch(0, 0, 0);
    chk("wrap_pc", PCOut, 16'h0001);
    pcload(16'h0100, 0);
    do_fetch(0, 5, 0);
    pcload(16'h1234, 1);
    idle(1);
    do_fetch(2, 3, 0);
    pcload(16'h0200, 0);
    do_fetch(1, 0, 1);
    idle(2);
`ifdef FETCH_TIMEOUT_EN
    pcload(16'h0010, 0);
    do_fetch(0, 0, 2);
    idle(1);
`endif
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0: pcload(16'($urandom), 1'($urandom));
        1: idle($urandom_range(1, 3));
        default: do_fetch($urandom_range(0, 3), $urandom_range(0, 3), 0);
      endcase
    end
    idle(3);
    chk("left_irwrites", wr_q.size(), 0);
    chk("left_done", done_q.size(), 0);
    chk("left_error", err_q.size(), 0);
    chk("final_pc", PCOut, model_pc);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ir_fetch_sequencer.md
IR_FETCH_SEQUENCER -- requirements
Module: ir_fetch_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, the program-counter and memory-address width.
REQ-002 SHALL have parameter TIMEOUT, default 15, the maximum number of wait cycles per byte; used only with FETCH_TIMEOUT_EN.
REQ-003 SHALL have port Clock  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  in  1  synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-005 SHALL have port Start  in  1  request to fetch one 16-bit instruction.
REQ-006 SHALL have port PCLoad  in  1  load PC from PCIn.
REQ-007 SHALL have port PCIn  in  ADDR_W  PC load value.
REQ-008 SHALL have port MemData  in  8  byte returned by memory.
REQ-009 SHALL have port MemReady  in  1  MemData valid this cycle.
REQ-010 SHALL have port MemRead  out  1  memory read request.
REQ-011 SHALL have port MemAddr  out  ADDR_W  read address, always equal to PCOut.
REQ-012 SHALL have port IRData  out  8  byte to the instruction register's I input.
REQ-013 SHALL have port IRWrite  out  1  instruction-register write strobe, one cycle per byte.
REQ-014 SHALL have port IRLH  out  1  half select for the register: 0 = low byte, 1 = high byte.
REQ-015 SHALL have port PCOut  out  ADDR_W  current PC.
REQ-016 SHALL have port Busy  out  1  high in any state other than IDLE.
REQ-017 SHALL have port Done  out  1  single-cycle pulse on completion.
REQ-018 SHALL have port Error  out  1  single-cycle timeout pulse; tied to 0 without FETCH_TIMEOUT_EN.

Function
REQ-019 SHALL implement the states IDLE, FETCH_LO and FETCH_HI; MemRead SHALL be high exactly in FETCH_LO and FETCH_HI.
REQ-020 In IDLE, Start=1 with PCLoad=0 SHALL move to FETCH_LO on the next cycle and save PCOut as StartPC.
REQ-021 In IDLE, PCLoad=1 SHALL set PC<=PCIn and ignore any Start in the same cycle; PCLoad SHALL be ignored while Busy.
REQ-022 Start while Busy SHALL be ignored.
REQ-023 In FETCH_LO, MemReady=1 SHALL produce, on the next cycle: IRData=MemData, IRWrite=1, IRLH=0, PC+1, state FETCH_HI.
REQ-024 In FETCH_HI, MemReady=1 SHALL produce, on the next cycle: IRData=MemData, IRWrite=1, IRLH=1, PC+1, Done=1, state IDLE.
REQ-025 MemReady SHALL be ignored in IDLE; while MemReady=0 a fetch state SHALL hold with all outputs stable.
REQ-026 PC increments SHALL wrap modulo 2^ADDR_W (0xFFFF+1 -> 0x0000).
REQ-027 The minimum Start-to-Done latency SHALL be 3 cycles.
REQ-028 IRWrite, Done and Error SHALL be registered outputs and never high for two consecutive cycles from the same event.

Reset
REQ-029 Reset SHALL dominate all other inputs, including mid-fetch.
REQ-030 Reset SHALL set state=IDLE, PC=0, IRData=0, IRWrite=0, IRLH=0, Done=0, Error=0, and clear the wait counter.
REQ-031 A reset mid-fetch SHALL produce no further IRWrite.

Configuration
REQ-032 With FETCH_TIMEOUT_EN defined, a wait counter SHALL clear on entry to each fetch state and increment each cycle MemReady=0.
REQ-033 With FETCH_TIMEOUT_EN defined, on reaching TIMEOUT the next cycle SHALL give Error=1, state IDLE, PC restored to StartPC, and no IRWrite.
REQ-034 Without FETCH_TIMEOUT_EN, the block SHALL contain no counter, SHALL wait indefinitely, and SHALL hold Error at 0.

Structure
REQ-035 Package ir_fetch_pkg SHALL hold the state enum (IDLE, FETCH_LO, FETCH_HI) and the default ADDR_W and TIMEOUT constants.
REQ-036 With FETCH_TIMEOUT_EN, the wait counter SHALL be the sub-module fetch_watchdog (inputs clear and enable, output expired); otherwise the design SHALL be a single module.

Verification
REQ-037 Reset, then PCLoad with PCIn=0x0040, then Start, with MemReady=1 and bytes 0x34 then 0x12 -> IRWrite with LH=0/0x34 and LH=1/0x12 at addresses 0x40 and 0x41, Done at cycle 3, PCOut=0x0042.
REQ-038 Wrap: PC=0xFFFF, fetch -> addresses 0xFFFF then 0x0000, final PCOut=0x0001.
REQ-039 MemReady low for 5 cycles in FETCH_HI -> MemRead and MemAddr held, a single high-byte IRWrite, Done 5 cycles later than the minimum.
REQ-040 Start and PCLoad together in IDLE -> PC=PCIn, Busy stays 0; Start and PCLoad while Busy -> no effect.
REQ-041 Reset asserted in FETCH_HI -> next cycle IDLE, PC=0, no IRWrite, no Done.
REQ-042 With FETCH_TIMEOUT_EN and MemReady held 0 after the low byte from StartPC=0x0010 -> Error after 15 wait cycles, PCOut=0x0010, no second IRWrite.
